// File: rtl/sd_init_seq_pkg.sv
// Shared types and constants for the SD card-initialisation sequencer:
// card classification, command indices, fixed arguments and FSM states.
package sd_pkg;

    typedef enum logic [1:0] {
        CT_UNKNOWN = 2'd0,
        CT_SDV1    = 2'd1,
        CT_SDV2    = 2'd2,
        CT_SDHC    = 2'd3
    } card_type_e;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD13  = 6'd13;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // CMD8: 2.7-3.6 V range plus 0xAA check pattern, echoed by v2 cards.
    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [31:0] ACMD41_ARG_HCS = 32'hC010_0000;
    localparam logic [31:0] ACMD41_ARG_SC  = 32'h0010_0000;
    localparam logic [31:0] CMD16_ARG      = 32'd512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sd_init_seq_if.sv
// Start/busy/done handshake between the init sequencer (master) and the
// SD command engine (slave).
interface sd_init_seq_if;
    // Handshake: master holds cmd_start with stable idx/arg/precnt until the
    // engine raises cmd_busy; the engine later pulses cmd_done for one cycle
    // with cmd_busy low, and cmd_timeout/cmd_syntaxe/cmd_resparg are valid
    // only in that done cycle.
    logic        cmd_start;
    logic [15:0] cmd_precnt;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_timeout;
    logic        cmd_syntaxe;
    logic [31:0] cmd_resparg;

    modport master (
        output cmd_start, cmd_precnt, cmd_idx, cmd_arg,
        input  cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe, cmd_resparg
    );

    modport slave (
        input  cmd_start, cmd_precnt, cmd_idx, cmd_arg,
        output cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe, cmd_resparg
    );
endinterface

// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: CMD0..CMD16 from power-up to transfer state.
// Optional SD_INIT_STATUS_EN adds a CMD13 transfer-state check after CMD16.
module sd_init_seq
    import sd_pkg::*;
#(
    parameter logic [15:0] SLOW_CLKDIV      = 16'd63,
    parameter logic [15:0] FAST_CLKDIV      = 16'd1,
    parameter logic [3:0]  CMD_RETRY_MAX    = 4'd3,
    parameter logic [15:0] ACMD41_RETRY_MAX = 16'd2000,
    parameter logic [15:0] PRECNT_FIRST     = 16'd64,
    parameter logic [15:0] PRECNT_CMD       = 16'd2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 init_req,
    output logic                 init_busy,
    output logic                 init_done,
    output logic                 init_fail,
    output logic [5:0]           fail_cmd,
    output logic [1:0]           card_type,
    output logic [15:0]          rca,
    output logic [15:0]          clkdiv,
    sd_init_seq_if.master        cmd,
    output seq_state_e           state_dbg
);

    seq_state_e  state_q, state_d;
    card_type_e  card_type_q, card_type_d;
    logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic        start_q, start_d, v1_q, v1_d;
    logic [5:0]  fail_cmd_q, fail_cmd_d, idx_q, idx_d;
    logic [15:0] rca_q, rca_d, clkdiv_q, clkdiv_d, precnt_q, precnt_d;
    logic [15:0] poll_q, poll_d;
    logic [31:0] arg_q, arg_d;
    logic [3:0]  retry_q, retry_d;

    logic        restart, issue, retry, finish, go_fail, err;
    logic [5:0]  nxt_idx;
    logic [31:0] nxt_arg;
    logic        unused_resp;

    assign unused_resp = ^cmd.cmd_resparg[15:12];
    assign err = cmd.cmd_timeout | cmd.cmd_syntaxe;

    always_comb begin
        state_d     = state_q;
        card_type_d = card_type_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        start_d     = start_q;
        v1_d        = v1_q;
        fail_cmd_d  = fail_cmd_q;
        idx_d       = idx_q;
        rca_d       = rca_q;
        clkdiv_d    = clkdiv_q;
        precnt_d    = precnt_q;
        poll_d      = poll_q;
        arg_d       = arg_q;
        retry_d     = retry_q;
        restart     = 1'b0;
        issue       = 1'b0;
        retry       = 1'b0;
        finish      = 1'b0;
        go_fail     = 1'b0;
        nxt_idx     = idx_q;
        nxt_arg     = arg_q;

        case (state_q)
            ST_IDLE: restart = 1'b1;
            ST_ISSUE: begin
                if (cmd.cmd_busy) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd.cmd_done) begin
                    retry_d = '0;
                    case (idx_q)
                        CMD0: begin
                            issue = 1'b1; nxt_idx = CMD8; nxt_arg = CMD8_ARG;
                        end
                        CMD8: begin
                            // A timeout here is the normal answer of a v1 card.
                            if (cmd.cmd_timeout) begin
                                v1_d = 1'b1; issue = 1'b1; nxt_idx = CMD55; nxt_arg = '0;
                            end else if (!cmd.cmd_syntaxe && cmd.cmd_resparg[11:0] == 12'h1AA) begin
                                v1_d = 1'b0; issue = 1'b1; nxt_idx = CMD55; nxt_arg = '0;
                            end else begin
                                go_fail = 1'b1;
                            end
                        end
                        CMD55: begin
                            if (err) retry = 1'b1;
                            else begin
                                issue = 1'b1; nxt_idx = ACMD41;
                                nxt_arg = v1_q ? ACMD41_ARG_SC : ACMD41_ARG_HCS;
                            end
                        end
                        ACMD41: begin
                            if (cmd.cmd_timeout) retry = 1'b1;
                            else if (cmd.cmd_resparg[31]) begin
                                card_type_d = v1_q ? CT_SDV1 : (cmd.cmd_resparg[30] ? CT_SDHC : CT_SDV2);
                                issue = 1'b1; nxt_idx = CMD2; nxt_arg = '0;
                            end else begin
                                poll_d = (poll_q == ACMD41_RETRY_MAX) ? poll_q : poll_q + 16'd1;
                                if (poll_q + 16'd1 >= ACMD41_RETRY_MAX) go_fail = 1'b1;
                                else begin
                                    issue = 1'b1; nxt_idx = CMD55; nxt_arg = '0;
                                end
                            end
                        end
                        CMD2: begin
                            if (cmd.cmd_timeout) retry = 1'b1;
                            else begin
                                issue = 1'b1; nxt_idx = CMD3; nxt_arg = '0;
                            end
                        end
                        CMD3: begin
                            if (err) retry = 1'b1;
                            else begin
                                rca_d = cmd.cmd_resparg[31:16];
                                issue = 1'b1; nxt_idx = CMD7; nxt_arg = {cmd.cmd_resparg[31:16], 16'h0};
                            end
                        end
                        CMD7: begin
                            if (err) retry = 1'b1;
                            else begin
                                issue = 1'b1; nxt_idx = CMD16; nxt_arg = CMD16_ARG;
                            end
                        end
                        CMD16: begin
                            if (err) retry = 1'b1;
`ifdef SD_INIT_STATUS_EN
                            else begin
                                issue = 1'b1; nxt_idx = CMD13; nxt_arg = {rca_q, 16'h0};
                            end
                        end
                        CMD13: begin
                            if (err) retry = 1'b1;
                            else if (cmd.cmd_resparg[12:9] == 4'd4) finish = 1'b1;
                            else go_fail = 1'b1;
`else
                            else finish = 1'b1;
`endif
                        end
                        default: go_fail = 1'b1;
                    endcase
                end
            end
            ST_DONE, ST_FAIL: restart = init_req;
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            done_d      = 1'b0;
            fail_d      = 1'b0;
            fail_cmd_d  = '0;
            card_type_d = CT_UNKNOWN;
            rca_d       = '0;
            retry_d     = '0;
            poll_d      = '0;
            v1_d        = 1'b0;
            clkdiv_d    = SLOW_CLKDIV;
            busy_d      = 1'b1;
            issue       = 1'b1;
            nxt_idx     = CMD0;
            nxt_arg     = '0;
        end

        if (retry) begin
            if (retry_q < CMD_RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                issue   = 1'b1;
            end else begin
                go_fail = 1'b1;
            end
        end

        if (issue) begin
            state_d  = ST_ISSUE;
            start_d  = 1'b1;
            idx_d    = nxt_idx;
            arg_d    = nxt_arg;
            precnt_d = (nxt_idx == CMD0) ? PRECNT_FIRST : PRECNT_CMD;
        end

        if (finish) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            clkdiv_d = FAST_CLKDIV;
        end

        if (go_fail) begin
            state_d    = ST_FAIL;
            fail_d     = 1'b1;
            busy_d     = 1'b0;
            fail_cmd_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            card_type_q <= CT_UNKNOWN;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            start_q     <= 1'b0;
            v1_q        <= 1'b0;
            fail_cmd_q  <= '0;
            idx_q       <= '0;
            rca_q       <= '0;
            clkdiv_q    <= SLOW_CLKDIV;
            precnt_q    <= PRECNT_FIRST;
            poll_q      <= '0;
            arg_q       <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            card_type_q <= card_type_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            start_q     <= start_d;
            v1_q        <= v1_d;
            fail_cmd_q  <= fail_cmd_d;
            idx_q       <= idx_d;
            rca_q       <= rca_d;
            clkdiv_q    <= clkdiv_d;
            precnt_q    <= precnt_d;
            poll_q      <= poll_d;
            arg_q       <= arg_d;
            retry_q     <= retry_d;
        end
    end

    assign init_busy      = busy_q;
    assign init_done      = done_q;
    assign init_fail      = fail_q;
    assign fail_cmd       = fail_cmd_q;
    assign card_type      = card_type_q;
    assign rca            = rca_q;
    assign clkdiv         = clkdiv_q;
    assign cmd.cmd_start  = start_q;
    assign cmd.cmd_precnt = precnt_q;
    assign cmd.cmd_idx    = idx_q;
    assign cmd.cmd_arg    = arg_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Bench for sd_init_seq: behavioural command engine plus command scoreboard.
module tb_sd_init_seq;
    import sd_pkg::*;

    localparam int W = 54;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        init_req = 1'b0;
    logic        init_busy, init_done, init_fail;
    logic [5:0]  fail_cmd;
    logic [1:0]  card_type;
    logic [15:0] rca, clkdiv;
    seq_state_e  state_dbg;

    sd_init_seq_if cif();

    sd_init_seq #(.ACMD41_RETRY_MAX(16'd5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .init_req  (init_req),
        .init_busy (init_busy),
        .init_done (init_done),
        .init_fail (init_fail),
        .fail_cmd  (fail_cmd),
        .card_type (card_type),
        .rca       (rca),
        .clkdiv    (clkdiv),
        .cmd       (cif),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc;
    event cmd_seen;

    // Card model knobs: 0 SDHC, 1 v1, 2 bad CMD8 echo, 3 ACMD41 never ready.
    int mode = 0;
    int polls41 = 0;
    int cmd3_to = 0;
    int busy_cnt = 0;
    logic [5:0] cur_idx = '0;
    bit saw41 = 1'b0;

    task automatic respond();
        case (cur_idx)
            6'd0: cif.cmd_timeout = 1'b1;
            6'd8: begin
                if (mode == 1) cif.cmd_timeout = 1'b1;
                else if (mode == 2) cif.cmd_resparg = 32'h0000_01A5;
                else cif.cmd_resparg = 32'h0000_01AA;
            end
            6'd55: cif.cmd_resparg = 32'h0000_0120;
            6'd41: begin
                cif.cmd_syntaxe = 1'b1;
                if (mode == 1) cif.cmd_resparg = 32'h80FF_8000;
                else if (mode == 3) cif.cmd_resparg = 32'h00FF_8000;
                else if (polls41 < 3) begin
                    polls41++;
                    cif.cmd_resparg = 32'h00FF_8000;
                end else cif.cmd_resparg = 32'hC0FF_8000;
            end
            6'd2: begin
                cif.cmd_syntaxe = 1'b1;
                cif.cmd_resparg = 32'h1234_5678;
            end
            6'd3: begin
                if (cmd3_to > 0) begin
                    cmd3_to--;
                    cif.cmd_timeout = 1'b1;
                end else cif.cmd_resparg = 32'h1234_0000;
            end
            default: cif.cmd_resparg = 32'h0000_0900;
        endcase
    endtask

    // Engine model: accepts start, stays busy for three cycles, then pulses done.
    always @(negedge clk) begin
        if (!rstn) begin
            cif.cmd_busy = 1'b0; cif.cmd_done = 1'b0; cif.cmd_timeout = 1'b0;
            cif.cmd_syntaxe = 1'b0; cif.cmd_resparg = '0; busy_cnt = 0;
        end else begin
            if (cif.cmd_done) begin
                cif.cmd_done = 1'b0; cif.cmd_timeout = 1'b0;
                cif.cmd_syntaxe = 1'b0; cif.cmd_resparg = '0;
            end
            if (cif.cmd_busy) begin
                if (busy_cnt == 0) begin
                    cif.cmd_busy = 1'b0;
                    cif.cmd_done = 1'b1;
                    respond();
                end else busy_cnt--;
            end else if (cif.cmd_start) begin
                acc = {cif.cmd_precnt, cif.cmd_idx, cif.cmd_arg};
                cur_idx = cif.cmd_idx;
                if (cif.cmd_idx == 6'd41) saw41 = 1'b1;
                cif.cmd_busy = 1'b1;
                busy_cnt = 2;
                -> cmd_seen;
            end
        end
    end

    always @(cmd_seen) begin
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cmd_issue: got precnt/idx/arg=%h, expected no start", acc);
        end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (acc !== e) begin
                bad++;
                $display("FAIL cmd_issue: got precnt/idx/arg=%h, expected %h", acc, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [15:0] pc;
        pc = (idx == 6'd0) ? 16'd64 : 16'd2;
        exp_q.push_back({pc, idx, arg});
    endtask

    task automatic push_head();
        push_cmd(6'd0, 32'h0);
        push_cmd(6'd8, 32'h0000_01AA);
    endtask

    task automatic push_pairs(input int n, input logic [31:0] a41);
        for (int i = 0; i < n; i++) begin
            push_cmd(6'd55, 32'h0);
            push_cmd(6'd41, a41);
        end
    endtask

    task automatic push_tail(input int n3);
        push_cmd(6'd2, 32'h0);
        for (int i = 0; i < n3; i++) push_cmd(6'd3, 32'h0);
        push_cmd(6'd7, 32'h1234_0000);
        push_cmd(6'd16, 32'd512);
`ifdef SD_INIT_STATUS_EN
        push_cmd(6'd13, 32'h1234_0000);
`endif
    endtask

    task automatic pulse_req();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (init_done || init_fail) break;
            @(negedge clk);
        end
        total++;
        if (i >= 3000) begin
            bad++;
            $display("FAIL %s_timeout: got no done/fail within 3000 cycles, expected an end", name);
        end
        repeat (20) @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_ok(input string name, input logic [1:0] ct);
        check({name, "_done"}, 32'(init_done), 32'd1);
        check({name, "_fail"}, 32'(init_fail), 32'd0);
        check({name, "_busy"}, 32'(init_busy), 32'd0);
        check({name, "_card_type"}, 32'(card_type), 32'(ct));
        check({name, "_rca"}, 32'(rca), 32'h1234);
        check({name, "_clkdiv"}, 32'(clkdiv), 32'd1);
        check({name, "_state"}, 32'(state_dbg), 32'(ST_DONE));
    endtask

    task automatic check_fail(input string name, input logic [5:0] fc);
        check({name, "_fail"}, 32'(init_fail), 32'd1);
        check({name, "_done"}, 32'(init_done), 32'd0);
        check({name, "_busy"}, 32'(init_busy), 32'd0);
        check({name, "_fail_cmd"}, 32'(fail_cmd), 32'(fc));
        check({name, "_clkdiv"}, 32'(clkdiv), 32'd63);
        check({name, "_start"}, 32'(cif.cmd_start), 32'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_busy"}, 32'(init_busy), 32'd0);
        check({name, "_done"}, 32'(init_done), 32'd0);
        check({name, "_fail"}, 32'(init_fail), 32'd0);
        check({name, "_fail_cmd"}, 32'(fail_cmd), 32'd0);
        check({name, "_card_type"}, 32'(card_type), 32'd0);
        check({name, "_rca"}, 32'(rca), 32'd0);
        check({name, "_clkdiv"}, 32'(clkdiv), 32'd63);
        check({name, "_start"}, 32'(cif.cmd_start), 32'd0);
        check({name, "_idx"}, 32'(cif.cmd_idx), 32'd0);
        check({name, "_arg"}, cif.cmd_arg, 32'd0);
        check({name, "_precnt"}, 32'(cif.cmd_precnt), 32'd64);
        check({name, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cmd_busy = 1'b0; cif.cmd_done = 1'b0; cif.cmd_timeout = 1'b0;
        cif.cmd_syntaxe = 1'b0; cif.cmd_resparg = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");

        // SDHC card, auto-start after reset release; three busy ACMD41 polls.
        mode = 0; polls41 = 0; cmd3_to = 0;
        push_head(); push_pairs(4, 32'hC010_0000); push_tail(1);
        @(negedge clk); rstn = 1'b1;
        wait_end("sdhc");
        check_ok("sdhc", 2'd3);

        // v1 card: CMD8 times out, ACMD41 uses the non-HCS argument.
        mode = 1;
        push_head(); push_pairs(1, 32'h0010_0000); push_tail(1);
        pulse_req();
        check("restart_busy", 32'(init_busy), 32'd1);
        check("restart_done", 32'(init_done), 32'd0);
        check("restart_card_type", 32'(card_type), 32'd0);
        check("restart_rca", 32'(rca), 32'd0);
        check("restart_clkdiv", 32'(clkdiv), 32'd63);
        wait_end("v1");
        check_ok("v1", 2'd1);

        // Wrong CMD8 echo: immediate fail, no further commands.
        mode = 2;
        push_head();
        pulse_req();
        wait_end("cmd8bad");
        check_fail("cmd8bad", 6'd8);

        // ACMD41 never ready: five pairs with the retry limit set to 5.
        mode = 3;
        push_head(); push_pairs(5, 32'hC010_0000);
        pulse_req();
        wait_end("acmd41");
        check_fail("acmd41", 6'd41);

        // CMD3 times out twice, third attempt succeeds.
        mode = 0; polls41 = 0; cmd3_to = 2;
        push_head(); push_pairs(4, 32'hC010_0000); push_tail(3);
        pulse_req();
        wait_end("cmd3retry");
        check_ok("cmd3retry", 2'd3);

        // CMD3 times out four times: retries exhausted.
        polls41 = 0; cmd3_to = 4;
        push_head(); push_pairs(4, 32'hC010_0000);
        push_cmd(6'd2, 32'h0);
        for (int i = 0; i < 4; i++) push_cmd(6'd3, 32'h0);
        pulse_req();
        wait_end("cmd3fail");
        check_fail("cmd3fail", 6'd3);

        // Reset while ACMD41 is in flight.
        polls41 = 0; cmd3_to = 0; saw41 = 1'b0;
        push_head(); push_pairs(4, 32'hC010_0000); push_tail(1);
        pulse_req();
        for (int i = 0; i < 500; i++) begin
            if (saw41) break;
            @(negedge clk);
        end
        check("saw_acmd41", 32'(saw41), 32'd1);
        rstn = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset("midrst");
        polls41 = 0;
        push_head(); push_pairs(4, 32'hC010_0000); push_tail(1);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check("busy_before_ignored_req", 32'(init_busy), 32'd1);
        pulse_req();
        wait_end("postrst");
        check_ok("postrst", 2'd3);

        // Restart from DONE: CMD0 again with the power-up precnt.
        polls41 = 0;
        push_head(); push_pairs(4, 32'hC010_0000); push_tail(1);
        pulse_req();
        wait_end("rerun");
        check_ok("rerun", 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_init_seq.md
Name: sd_init_seq

Overview:
Card-initialisation sequencer that drives the SD command engine (the sdcmd_ctrl start/cmd/arg/busy/done interface) from power-up to transfer state. It owns the engine's clkdiv and issues the fixed sequence below:
- CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7, CMD16.
- It classifies the card, captures the RCA and switches to the fast clock.
- It sits between the sector-read logic and the command engine; readers may issue commands only after init_done.

Parameters:
SLOW_CLKDIV, 16'd63, clkdiv during identification (≈400 kHz)
FAST_CLKDIV, 16'd1, clkdiv after init_done
CMD_RETRY_MAX, 4'd3, retries per command on timeout/syntax error before fail
ACMD41_RETRY_MAX, 16'd2000, CMD55+ACMD41 pairs before fail
PRECNT_FIRST, 16'd64, precnt for CMD0 (power-up clocks)
PRECNT_CMD, 16'd2, precnt for all later commands

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
init_req  in  1  pulse; restart init from IDLE, DONE or FAIL; ignored while running
init_busy  out  1  sequence in progress
init_done  out  1  level; card in transfer state
init_fail  out  1  level; sequence aborted
fail_cmd  out  6  command index that caused the failure
card_type  out  2  0 unknown, 1 SDv1, 2 SDv2-SC, 3 SDHC/SDXC
rca  out  16  relative card address from CMD3
clkdiv  out  16  to command engine
cmd_start  out  1  to engine start
cmd_precnt  out  16  to engine precnt
cmd_idx  out  6  to engine cmd
cmd_arg  out  32  to engine arg
cmd_busy  in  1  engine busy
cmd_done  in  1  engine done pulse
cmd_timeout  in  1  engine timeout (valid with done)
cmd_syntaxe  in  1  engine syntax error (valid with done)
cmd_resparg  in  32  engine response argument

Behaviour:
- Reset state: init_busy/done/fail=0, fail_cmd=0, card_type=0, rca=0, clkdiv=SLOW_CLKDIV, cmd_start=0, cmd_idx=0, cmd_arg=0, cmd_precnt=PRECNT_FIRST, state IDLE.
- Auto-start: first clock after rstn release, IDLE→CMD0 automatically.
- Command handshake, two sub-states per command:
  - ISSUE: present idx/arg/precnt and hold cmd_start=1 until cmd_busy=1.
  - WAIT: cmd_start=0; on cmd_done, evaluate the response (cmd_timeout, cmd_syntaxe, cmd_resparg sampled in the done cycle), then select the next command.
  - idx/arg stay stable from ISSUE through done.
  - Never assert start while cmd_busy=1; no extra idle cycle needed.
- Error result = timeout or syntaxe, unless stated otherwise.
  - On an error result, reissue the same command while retry count < CMD_RETRY_MAX.
  - When retries are exhausted → FAIL with fail_cmd = cmd.
  - Retry count clears on every successful command.
- Per-command flow:
  - CMD0 (arg 0, precnt PRECNT_FIRST): any result accepted (no response expected) → CMD8.
  - CMD8 (arg 0x000001AA):
    - timeout → v1=1 → CMD55.
    - resparg[11:0]==0x1AA → v1=0 → CMD55.
    - any other value or syntaxe → FAIL (no retry).
  - CMD55 (arg 0): on success → ACMD41.
  - ACMD41 (cmd 41, arg 0xC0100000 if v2 else 0x00100000; syntaxe ignored, R3 carries no index/CRC):
    - resparg[31]=1 → card_type = v1 ? 1 : (resparg[30] ? 3 : 2) → CMD2.
    - else increment poll counter → CMD55.
    - poll counter reaching ACMD41_RETRY_MAX → FAIL (fail_cmd=41).
  - CMD2 (arg 0): syntaxe ignored (R2) → CMD3.
  - CMD3 (arg 0): rca ← resparg[31:16] → CMD7.
  - CMD7 (arg {rca,16'h0}) → CMD16.
  - CMD16 (arg 512) → DONE.
- DONE: clkdiv←FAST_CLKDIV, init_done=1, init_busy=0.
- FAIL: init_fail=1, init_busy=0, clkdiv stays SLOW.
- init_req in IDLE/DONE/FAIL:
  - clear done/fail/card_type/rca/counters; clkdiv←SLOW_CLKDIV; → CMD0.
  - init_busy=1 from the next cycle.
- Width rules: ACMD41 poll counter 16-bit, saturating at ACMD41_RETRY_MAX; retry counter 4-bit.
- Reset mid-command: all state returns to reset values. The engine resets on the same rstn, so no orphan handshake is left.

Optional Feature:
SD_INIT_STATUS_EN:
- Defined: after CMD16 issue CMD13 (arg {rca,16'h0}).
  - resparg[12:9]==4'd4 (tran) → DONE.
  - else → FAIL with fail_cmd=13; normal timeout retries apply.
- Undefined: CMD16 goes directly to DONE; no CMD13 logic.

Decomposition:
- Package sd_pkg:
  - card_type enum (CT_UNKNOWN, CT_SDV1, CT_SDV2, CT_SDHC).
  - Command index constants (CMD0, CMD2, CMD3, CMD7, CMD8, CMD13, CMD16, CMD55, ACMD41).
  - CMD8_ARG, ACMD41_ARG_HCS/ACMD41_ARG_SC.
  - Sequencer state enum.
- No sub-module: single FSM plus counters; the command engine is instantiated by the parent.

Test Plan:
- SDHC model (CMD8 echoes 0x1AA, ACMD41 busy for 3 polls, then resparg=0xC0FF8000, CMD3 resparg=0x12340000) → card_type=3, rca=0x1234, CMD7 arg=0x12340000, init_done=1, clkdiv=FAST_CLKDIV.
- v1 card (CMD8 timeout, ACMD41 resparg=0x80FF8000) → card_type=1, all ACMD41 args=0x00100000, init_done=1.
- CMD8 returns 0x000001A5 → init_fail=1, fail_cmd=8, clkdiv=SLOW_CLKDIV, no further starts.
- ACMD41 never ready, ACMD41_RETRY_MAX=5 → exactly 5 CMD55/ACMD41 pairs, then init_fail=1, fail_cmd=41.
- CMD3 times out twice then succeeds → three CMD3 starts, success; with 4 timeouts → fail_cmd=3.
- rstn pulsed while ACMD41 in flight, then init_req after DONE → outputs back to reset values, CMD0 reissued with precnt=64; init_req during busy ignored.
